// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 SPI byte transmitter.
package ssd1306_pkg;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // SPI mode 3: clock idles high, data launched on falling edge.
    localparam int unsigned SPI_MODE  = 3;
    localparam logic        SCK_IDLE  = 1'b1;
    localparam logic        CSN_IDLE  = 1'b1;
    localparam logic        MOSI_RST  = 1'b0;

endpackage

// File: rtl/ssd1306_sck_tick.sv
// Restartable divider: one-cycle tick every CLK_DIV enabled cycles.
module ssd1306_sck_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic resetn_in,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = en_i && !restart_i && (cnt_q == TERM);

    // Next count: clear when disabled, restarted or on terminal count.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (restart_i || !en_i || tick_o)
            cnt_d = 8'd0;
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) cnt_q <= 8'd0;
        else            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ssd1306_spi_tx.sv
// SPI mode-3 byte transmitter for the SSD1306 microcode executor.
// One byte per trigger, MSB first; CS is held low across non-last bytes.
module ssd1306_spi_tx
    import ssd1306_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk_in,
    input  logic       resetn_in,
    input  logic       tx_trigger_in,
    input  logic [7:0] data_in,
    input  logic       last_byte_in,
    output logic       ready_out,
    output logic       spi_sck_out,
    output logic       spi_mosi_out,
    output logic       spi_csn_out
);

    state_e     state_q, state_d;
    logic [6:0] sh_q, sh_d;        // bits still to be sent after the current one
    logic [2:0] bit_q, bit_d;
    logic       phase_q, phase_d;  // second half of SCK bit / of CS hold
    logic       last_q, last_d;
    logic       armed_q, armed_d;  // trigger has been low since last accept
    logic       ready_q, ready_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       csn_q, csn_d;

    logic accept;
    logic tick;

    // A held trigger must drop before it can start another byte.
    assign accept = tx_trigger_in && ready_q && armed_q;

    ssd1306_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_in    (clk_in),
        .resetn_in (resetn_in),
        .en_i      (state_q != ST_IDLE),
        .restart_i (accept),
        .tick_o    (tick)
    );

    // FSM next-state and output register logic.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        last_d  = last_q;
        ready_d = ready_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        armed_d = armed_q;
        if (!tx_trigger_in) armed_d = 1'b1;
        if (accept)         armed_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_d    = data_in[6:0];
                    mosi_d  = data_in[7];
                    last_d  = last_byte_in;
                    ready_d = 1'b0;
                    bit_d   = 3'd0;
                    phase_d = 1'b0;
                    if (csn_q) begin
                        // CS setup time before the first falling edge.
                        state_d = ST_SETUP;
                        csn_d   = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                        sck_d   = 1'b0;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        sck_d   = 1'b1;
                        phase_d = 1'b1;
                    end else if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        phase_d = 1'b0;
                        if (last_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_IDLE;
                            ready_d = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        phase_d = 1'b0;
                        sck_d   = 1'b0;
                        mosi_d  = sh_q[6];
                        sh_d    = {sh_q[5:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (!phase_q) begin
                        csn_d   = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output flops; reset aborts any byte in flight.
    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q <= ST_IDLE;
            sh_q    <= 7'd0;
            bit_q   <= 3'd0;
            phase_q <= 1'b0;
            last_q  <= 1'b0;
            armed_q <= 1'b1;
            ready_q <= 1'b1;
            sck_q   <= SCK_IDLE;
            mosi_q  <= MOSI_RST;
            csn_q   <= CSN_IDLE;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            ready_q <= ready_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
        end
    end

    assign ready_out    = ready_q;
    assign spi_sck_out  = sck_q;
    assign spi_mosi_out = mosi_q;
    assign spi_csn_out  = csn_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Self-checking bench for ssd1306_spi_tx (CLK_DIV=2 and CLK_DIV=1 instances).
module tb_ssd1306_spi_tx;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       trig_a = 1'b0, last_a = 1'b0, trig_b = 1'b0, last_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic       rdy_a, sck_a, mosi_a, csn_a;
    logic       rdy_b, sck_b, mosi_b, csn_b;

    ssd1306_spi_tx #(.CLK_DIV(2)) u_a (
        .clk_in(clk), .resetn_in(rstn), .tx_trigger_in(trig_a), .data_in(data_a),
        .last_byte_in(last_a), .ready_out(rdy_a), .spi_sck_out(sck_a),
        .spi_mosi_out(mosi_a), .spi_csn_out(csn_a));

    ssd1306_spi_tx #(.CLK_DIV(1)) u_b (
        .clk_in(clk), .resetn_in(rstn), .tx_trigger_in(trig_b), .data_in(data_b),
        .last_byte_in(last_b), .ready_out(rdy_b), .spi_sck_out(sck_b),
        .spi_mosi_out(mosi_b), .spi_csn_out(csn_b));

    always #5 clk = ~clk;

    int vec = 0, err = 0, cyc = 0;
    int mode_viol = 0, csn_rise_a = 0;
    bit cap_a[$], exp_a[$], cap_b[$];
    int rise_b[$];
    logic psck_a = 1'b1, pcsn_a = 1'b1, pmosi_a = 1'b0, psck_b = 1'b1;

    // Line monitor: sample MOSI on each rising SCK while CS is low.
    always @(negedge clk) begin
        cyc++;
        if (sck_a === 1'b1 && psck_a === 1'b0 && csn_a === 1'b0) cap_a.push_back(mosi_a);
        if (sck_a === 1'b1 && psck_a === 1'b1 && csn_a === 1'b0 && pcsn_a === 1'b0 &&
            mosi_a !== pmosi_a) mode_viol++;
        if (csn_a === 1'b1 && pcsn_a === 1'b0) csn_rise_a++;
        psck_a = sck_a; pcsn_a = csn_a; pmosi_a = mosi_a;
        if (sck_b === 1'b1 && psck_b === 1'b0 && csn_b === 1'b0) begin
            cap_b.push_back(mosi_b);
            rise_b.push_back(cyc);
        end
        psck_b = sck_b;
    end

    // Reference model: bits go out MSB first; busy time from the CS/last rules.
    task automatic model_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) exp_a.push_back(d[i]);
    endtask

    function automatic int exp_busy(input int div, input bit cs_high, input bit last);
        return 16 * div + div * int'(cs_high) + 2 * div * int'(last);
    endfunction

    function automatic logic [63:0] pack(input bit q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[62:0], q[i]};
        return v;
    endfunction

    function automatic logic rdy_of(input bit b);
        return b ? rdy_b : rdy_a;
    endfunction

    // Drive one byte and measure how many cycles ready stays low.
    task automatic send(input bit b, input logic [7:0] d, input logic l,
                        output int busy, output bit acc);
        int g = 0;
        while (rdy_of(b) !== 1'b1 && g < 500) begin @(negedge clk); g++; end
        if (b) begin trig_b = 1'b1; data_b = d; last_b = l; end
        else   begin trig_a = 1'b1; data_a = d; last_a = l; end
        @(negedge clk);
        acc = (rdy_of(b) === 1'b0);
        trig_a = 1'b0; trig_b = 1'b0;
        busy = 0; g = 0;
        while (rdy_of(b) !== 1'b1 && g < 2000) begin busy++; @(negedge clk); g++; end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        vec++; if (rdy_a !== 1'b1) begin err++; $display("FAIL reset_ready: got %b want 1", rdy_a); end
        vec++; if (sck_a !== 1'b1) begin err++; $display("FAIL reset_sck: got %b want 1", sck_a); end
        vec++; if (csn_a !== 1'b1) begin err++; $display("FAIL reset_csn: got %b want 1", csn_a); end
        vec++; if (mosi_a !== 1'b0) begin err++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
        vec++; if ({rdy_b, sck_b, csn_b, mosi_b} !== 4'b1110)
            begin err++; $display("FAIL reset_b: got %b want 1110", {rdy_b, sck_b, csn_b, mosi_b}); end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if ({rdy_a, sck_a, csn_a} !== 3'b111)
            begin err++; $display("FAIL idle_after_reset: got %b want 111", {rdy_a, sck_a, csn_a}); end
    endtask

    task automatic test_single();
        int busy, r0, m0; bit acc;
        cap_a.delete(); exp_a.delete(); r0 = csn_rise_a; m0 = mode_viol;
        model_byte(8'hA5);
        send(1'b0, 8'hA5, 1'b1, busy, acc);
        vec++; if (!acc) begin err++; $display("FAIL single_accept: got 0 want 1"); end
        vec++; if (busy != exp_busy(2, 1, 1))
            begin err++; $display("FAIL single_busy: got %0d want %0d", busy, exp_busy(2, 1, 1)); end
        vec++; if (cap_a.size() != 8 || pack(cap_a) !== pack(exp_a))
            begin err++; $display("FAIL single_bits: got %0d bits %h want 8 bits %h", cap_a.size(), pack(cap_a), pack(exp_a)); end
        vec++; if (csn_rise_a - r0 != 1 || csn_a !== 1'b1)
            begin err++; $display("FAIL single_cs: got %0d rises csn=%b want 1 rise csn=1", csn_rise_a - r0, csn_a); end
        vec++; if (mode_viol != m0) begin err++; $display("FAIL single_mode3: got %0d violations want 0", mode_viol - m0); end
    endtask

    task automatic test_multi();
        logic [7:0] d [3];
        bit         l [3];
        int busy, r0, m0; bit acc, cs_high;
        d[0] = 8'h81; d[1] = 8'h7F; d[2] = 8'hAF;
        l[0] = 1'b0;  l[1] = 1'b0;  l[2] = 1'b1;
        cap_a.delete(); exp_a.delete(); r0 = csn_rise_a; m0 = mode_viol; cs_high = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_byte(d[i]);
            send(1'b0, d[i], l[i], busy, acc);
            vec++; if (!acc || busy != exp_busy(2, cs_high, l[i]))
                begin err++; $display("FAIL multi_busy%0d: got acc=%b busy=%0d want acc=1 busy=%0d", i, acc, busy, exp_busy(2, cs_high, l[i])); end
            if (i < 2) begin
                vec++; if (csn_a !== 1'b0) begin err++; $display("FAIL multi_cs_low%0d: got %b want 0", i, csn_a); end
            end
            cs_high = l[i];
        end
        vec++; if (cap_a.size() != 24 || pack(cap_a) !== pack(exp_a))
            begin err++; $display("FAIL multi_bits: got %0d bits %h want 24 bits %h", cap_a.size(), pack(cap_a), pack(exp_a)); end
        vec++; if (csn_rise_a - r0 != 1) begin err++; $display("FAIL multi_cs_rises: got %0d want 1", csn_rise_a - r0); end
        vec++; if (mode_viol != m0) begin err++; $display("FAIL multi_mode3: got %0d violations want 0", mode_viol - m0); end
    endtask

    task automatic test_trigger_held();
        int falls = 0, g = 0; logic prev;
        cap_a.delete(); exp_a.delete();
        model_byte(8'h5A);
        trig_a = 1'b1; data_a = 8'h5A; last_a = 1'b1; prev = rdy_a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && rdy_a === 1'b0) falls++;
            prev = rdy_a;
        end
        trig_a = 1'b0;
        while (rdy_a !== 1'b1 && g < 200) begin @(negedge clk); g++; end
        repeat (5) @(negedge clk);
        vec++; if (falls != 1) begin err++; $display("FAIL held_accepts: got %0d want 1", falls); end
        vec++; if (cap_a.size() != 8 || pack(cap_a) !== pack(exp_a) || rdy_a !== 1'b1)
            begin err++; $display("FAIL held_bits: got %0d bits %h rdy=%b want 8 bits %h rdy=1", cap_a.size(), pack(cap_a), rdy_a, pack(exp_a)); end
    endtask

    task automatic test_busy_ignored();
        int busy = 0, g = 0, stay = 0;
        cap_a.delete(); exp_a.delete();
        model_byte(8'hC3);
        while (rdy_a !== 1'b1 && g < 200) begin @(negedge clk); g++; end
        trig_a = 1'b1; data_a = 8'hC3; last_a = 1'b1;
        @(negedge clk);
        g = 0;
        while (rdy_a !== 1'b1 && g < 500) begin
            busy++;
            trig_a = (busy >= 10 && busy < 13);
            data_a = 8'h00; last_a = 1'b0;
            @(negedge clk); g++;
        end
        trig_a = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (rdy_a === 1'b1) stay++; end
        vec++; if (busy != exp_busy(2, 1, 1))
            begin err++; $display("FAIL busy_ignore_time: got %0d want %0d", busy, exp_busy(2, 1, 1)); end
        vec++; if (cap_a.size() != 8 || pack(cap_a) !== pack(exp_a))
            begin err++; $display("FAIL busy_ignore_bits: got %0d bits %h want 8 bits %h", cap_a.size(), pack(cap_a), pack(exp_a)); end
        vec++; if (stay != 6) begin err++; $display("FAIL busy_ignore_idle: got %0d ready cycles want 6", stay); end
    endtask

    task automatic test_reset_mid();
        int busy, g = 0; bit acc;
        cap_a.delete(); exp_a.delete();
        trig_a = 1'b1; data_a = 8'h96; last_a = 1'b0;
        @(negedge clk);
        trig_a = 1'b0;
        while (cap_a.size() < 3 && g < 200) begin @(negedge clk); #1; g++; end
        vec++; if (cap_a.size() != 3) begin err++; $display("FAIL midreset_reach: got %0d edges want 3", cap_a.size()); end
        rstn = 1'b0;
        #1;
        vec++; if ({sck_a, csn_a, rdy_a} !== 3'b111)
            begin err++; $display("FAIL midreset_outputs: got %b want 111", {sck_a, csn_a, rdy_a}); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        cap_a.delete(); exp_a.delete();
        model_byte(8'h3C);
        send(1'b0, 8'h3C, 1'b1, busy, acc);
        vec++; if (!acc || busy != exp_busy(2, 1, 1))
            begin err++; $display("FAIL midreset_busy: got acc=%b busy=%0d want acc=1 busy=%0d", acc, busy, exp_busy(2, 1, 1)); end
        vec++; if (cap_a.size() != 8 || pack(cap_a) !== pack(exp_a))
            begin err++; $display("FAIL midreset_bits: got %0d bits %h want 8 bits %h", cap_a.size(), pack(cap_a), pack(exp_a)); end
    endtask

    task automatic test_clkdiv1();
        int busy; bit acc;
        cap_b.delete(); rise_b.delete();
        send(1'b1, 8'hFF, 1'b1, busy, acc);
        vec++; if (!acc || busy != exp_busy(1, 1, 1))
            begin err++; $display("FAIL div1_busy: got acc=%b busy=%0d want acc=1 busy=%0d", acc, busy, exp_busy(1, 1, 1)); end
        vec++; if (cap_b.size() != 8 || pack(cap_b) !== 64'hFF)
            begin err++; $display("FAIL div1_bits: got %0d bits %h want 8 bits ff", cap_b.size(), pack(cap_b)); end
        if (rise_b.size() == 8) begin
            vec++; if (rise_b[7] - rise_b[0] != 14 || rise_b[1] - rise_b[0] != 2)
                begin err++; $display("FAIL div1_period: got span %0d step %0d want 14 and 2", rise_b[7] - rise_b[0], rise_b[1] - rise_b[0]); end
        end
    endtask

    task automatic test_back_to_back_random();
        int busy, r0, m0, nlast = 0; bit acc, cs_high, l; logic [7:0] d;
        cap_a.delete(); exp_a.delete(); r0 = csn_rise_a; m0 = mode_viol; cs_high = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            l = (i == 7) ? 1'b1 : 1'($urandom_range(0, 1));
            model_byte(d);
            send(1'b0, d, l, busy, acc);
            vec++; if (!acc || busy != exp_busy(2, cs_high, l))
                begin err++; $display("FAIL rand_byte%0d(%h,%b): got acc=%b busy=%0d want acc=1 busy=%0d", i, d, l, acc, busy, exp_busy(2, cs_high, l)); end
            cs_high = l;
            if (l) nlast++;
        end
        vec++; if (cap_a.size() != 64 || pack(cap_a) !== pack(exp_a))
            begin err++; $display("FAIL rand_bits: got %0d bits %h want 64 bits %h", cap_a.size(), pack(cap_a), pack(exp_a)); end
        vec++; if (csn_rise_a - r0 != nlast)
            begin err++; $display("FAIL rand_cs_rises: got %0d want %0d", csn_rise_a - r0, nlast); end
        vec++; if (mode_viol != m0) begin err++; $display("FAIL rand_mode3: got %0d violations want 0", mode_viol - m0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_trigger_held();
        test_busy_ignored();
        test_reset_mid();
        test_clkdiv1();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
